// File: rtl/log_rr_arbiter.sv
// log_rr_arbiter: round-robin front end for the central logger.
// Shares one log sink among NUM_CLIENTS requesters, drops requests below the
// run-time severity level (acknowledging them), and holds one registered entry
// for the sink behind a valid/ready handshake. Keeps saturating forward/drop counts.
// Optional feature: define LOG_ARB_TIMESTAMP_EN to add a free-running TS_W-bit
// timestamp captured into out_ts at each forwarded grant.
module log_rr_arbiter #(
   parameter int unsigned NUM_CLIENTS = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TS_W        = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              cfg_valid,
   input  logic [1:0]                        cfg_level,
   input  logic [NUM_CLIENTS-1:0]            req_valid,
   input  logic [2*NUM_CLIENTS-1:0]          req_type,
   input  logic [DATA_W*NUM_CLIENTS-1:0]     req_data,
   output logic [NUM_CLIENTS-1:0]            req_ready,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [1:0]                        out_type,
   output logic [DATA_W-1:0]                 out_data,
   output logic [$clog2(NUM_CLIENTS)-1:0]    out_src,
`ifdef LOG_ARB_TIMESTAMP_EN
   output logic [TS_W-1:0]                   out_ts,
`endif
   output logic [15:0]                       fwd_count,
   output logic [15:0]                       drop_count
);

   localparam int unsigned        SRC_W = $clog2(NUM_CLIENTS);
   localparam logic [SRC_W:0]     NUM_W = (SRC_W+1)'(NUM_CLIENTS);
   localparam logic [SRC_W-1:0]   LAST  = SRC_W'(NUM_CLIENTS - 1);

   typedef enum logic [1:0] {
      LVL_OFF     = 2'd0,
      LVL_ERROR   = 2'd1,
      LVL_WARNING = 2'd2,
      LVL_INFO    = 2'd3
   } level_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   level_e              level_q, level_d;
   logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [1:0]          out_type_q, out_type_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [SRC_W-1:0]    out_src_q, out_src_d;
   logic [15:0]         fwd_count_q, fwd_count_d;
   logic [15:0]         drop_count_q, drop_count_d;

   logic [1:0]          type_a [NUM_CLIENTS];
   logic [DATA_W-1:0]   data_a [NUM_CLIENTS];

   logic                grant_found;
   logic [SRC_W-1:0]    grant_idx;
   logic [SRC_W:0]      scan_sum;
   logic                grant_pass;
   logic                can_accept;
   logic                grant_accept;
   logic                fwd_accept;
   logic                drop_accept;
   logic                drain;

   // Severity filter: type 3 (reserved) only reaches the sink at INFO level.
   function automatic logic passes(input logic [1:0] typ, input level_e lvl);
      logic ok;
      case (lvl)
         LVL_INFO:    ok = 1'b1;
         LVL_WARNING: ok = (typ == 2'd1) || (typ == 2'd2);
         LVL_ERROR:   ok = (typ == 2'd2);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

   for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
      assign type_a[gi] = req_type[2*gi +: 2];
      assign data_a[gi] = req_data[DATA_W*gi +: DATA_W];
   end

   // Round-robin scan: first valid client starting at rr_ptr, wrapping mod NUM_CLIENTS.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         scan_sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(i);
         if (scan_sum >= NUM_W) scan_sum = scan_sum - NUM_W;
         if (!grant_found && req_valid[scan_sum[SRC_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_sum[SRC_W-1:0];
         end
      end
   end

   // Accept decision and next-state computation for every register.
   always_comb begin
      grant_pass   = passes(type_a[grant_idx], level_q);
      can_accept   = (state_q == ST_EMPTY) || out_ready;
      // Filtered grants never touch the output register, so they need no space.
      grant_accept = grant_found && (!grant_pass || can_accept);
      fwd_accept   = grant_accept && grant_pass;
      drop_accept  = grant_accept && !grant_pass;
      drain        = (state_q == ST_FULL) && out_ready;

      req_ready = grant_accept ? (NUM_CLIENTS'(1) << grant_idx) : '0;

      level_d  = cfg_valid ? level_e'(cfg_level) : level_q;
      rr_ptr_d = rr_ptr_q;
      if (grant_accept) rr_ptr_d = (grant_idx == LAST) ? '0 : grant_idx + SRC_W'(1);

      state_d    = state_q;
      out_type_d = out_type_q;
      out_data_d = out_data_q;
      out_src_d  = out_src_q;
      if (fwd_accept) begin
         state_d    = ST_FULL;
         out_type_d = type_a[grant_idx];
         out_data_d = data_a[grant_idx];
         out_src_d  = grant_idx;
      end else if (drain) begin
         state_d = ST_EMPTY;
      end

      fwd_count_d = fwd_count_q;
      if (drain && (fwd_count_q != '1)) fwd_count_d = fwd_count_q + 16'd1;
      drop_count_d = drop_count_q;
      if (drop_accept && (drop_count_q != '1)) drop_count_d = drop_count_q + 16'd1;
   end

   // Arbiter state, output entry register and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         level_q      <= LVL_OFF;
         rr_ptr_q     <= '0;
         out_type_q   <= '0;
         out_data_q   <= '0;
         out_src_q    <= '0;
         fwd_count_q  <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         rr_ptr_q     <= rr_ptr_d;
         out_type_q   <= out_type_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         fwd_count_q  <= fwd_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_valid  = (state_q == ST_FULL);
   assign out_type   = out_type_q;
   assign out_data   = out_data_q;
   assign out_src    = out_src_q;
   assign fwd_count  = fwd_count_q;
   assign drop_count = drop_count_q;

`ifdef LOG_ARB_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, ts_d;
   logic [TS_W-1:0] out_ts_q, out_ts_d;

   // Free-running timestamp; the grant-cycle value travels with the entry.
   always_comb begin
      ts_d     = ts_q + TS_W'(1);
      out_ts_d = fwd_accept ? ts_q : out_ts_q;
   end

   // Timestamp counter and captured entry timestamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q     <= '0;
         out_ts_q <= '0;
      end else begin
         ts_q     <= ts_d;
         out_ts_q <= out_ts_d;
      end
   end

   assign out_ts = out_ts_q;
`else
   // TS_W only sizes the timestamp path, which is absent in this build.
   if (TS_W == 0) begin : g_no_ts
   end
`endif

endmodule

// File: tb/tb_log_rr_arbiter.sv
// tb_log_rr_arbiter: table-driven filter/grant vectors plus hand-written
// sequences; forwarded entries are checked against a scoreboard queue.
module tb_log_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic [1:0]  cfg_level;
   logic [3:0]  req_valid;
   logic [7:0]  req_type;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_type;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic [15:0] fwd_count;
   logic [15:0] drop_count;
`ifdef LOG_ARB_TIMESTAMP_EN
   logic [15:0] out_ts;
`endif

   log_rr_arbiter #(.NUM_CLIENTS(4), .DATA_W(8), .TS_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_level  (cfg_level),
      .req_valid  (req_valid),
      .req_type   (req_type),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_type   (out_type),
      .out_data   (out_data),
      .out_src    (out_src),
`ifdef LOG_ARB_TIMESTAMP_EN
      .out_ts     (out_ts),
`endif
      .fwd_count  (fwd_count),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] lvl;
      logic [3:0] valid;
      logic [7:0] types;
      logic [3:0] exp_ready;
      logic       exp_entry;
      logic [1:0] exp_src;
   } vec_t;

   vec_t        vecs [12];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [11:0] sb_q [$];
   logic [3:0]  rdy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: sample req_ready and the sink handshake on the falling edge,
   // then let accepted clients withdraw unless they keep requesting.
   task automatic tick(input bit keep);
      logic [11:0] exp_e;
      @(negedge clk);
      rdy = req_ready;
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got entry %0h with none expected", {out_src, out_type, out_data});
         end else begin
            exp_e = sb_q.pop_front();
            chk("sb_entry", 32'({out_src, out_type, out_data}), 32'(exp_e));
         end
      end
      @(posedge clk);
      #1;
      if (!keep) req_valid = req_valid & ~rdy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      sb_q.delete();
      req_valid = '0;
      cfg_valid = 1'b0;
   endtask

   task automatic set_level(input logic [1:0] l);
      cfg_valid = 1'b1;
      cfg_level = l;
      tick(1'b0);
      cfg_valid = 1'b0;
   endtask

   task automatic set_client(input int i, input logic [1:0] t, input logic [7:0] d);
      req_valid[i]       = 1'b1;
      req_type[2*i +: 2] = t;
      req_data[8*i +: 8] = d;
   endtask

   task automatic push(input logic [1:0] s, input logic [1:0] t, input logic [7:0] d);
      sb_q.push_back({s, t, d});
   endtask

   initial begin
      logic [1:0] et;
      // level: 0 OFF 1 ERROR 2 WARNING 3 INFO; types packed {t3,t2,t1,t0}
      vecs[0]  = '{2'd3, 4'b0001, 8'h00, 4'b0001, 1'b1, 2'd0};
      vecs[1]  = '{2'd2, 4'b0001, 8'h00, 4'b0001, 1'b0, 2'd0};
      vecs[2]  = '{2'd2, 4'b0010, 8'h04, 4'b0010, 1'b1, 2'd1};
      vecs[3]  = '{2'd1, 4'b0100, 8'h10, 4'b0100, 1'b0, 2'd0};
      vecs[4]  = '{2'd1, 4'b1000, 8'h80, 4'b1000, 1'b1, 2'd3};
      vecs[5]  = '{2'd1, 4'b0001, 8'h03, 4'b0001, 1'b0, 2'd0};
      vecs[6]  = '{2'd3, 4'b0001, 8'h03, 4'b0001, 1'b1, 2'd0};
      vecs[7]  = '{2'd0, 4'b0100, 8'h20, 4'b0100, 1'b0, 2'd0};
      vecs[8]  = '{2'd3, 4'b1010, 8'h00, 4'b0010, 1'b1, 2'd1};
      vecs[9]  = '{2'd2, 4'b0000, 8'hFF, 4'b0000, 1'b0, 2'd0};
      vecs[10] = '{2'd2, 4'b1001, 8'h40, 4'b0001, 1'b0, 2'd0};
      vecs[11] = '{2'd1, 4'b0110, 8'h28, 4'b0010, 1'b1, 2'd1};

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_level = '0; out_ready = 1'b1;
      req_valid = '0; req_type = '0; req_data = '0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_entry", 32'({out_src, out_type, out_data}), 0);
      chk("rst_fwd", 32'(fwd_count), 0);
      chk("rst_drop", 32'(drop_count), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table: single request pattern from a fresh reset.
      for (int v = 0; v < 12; v++) begin
         do_reset();
         set_level(vecs[v].lvl);
         req_type  = vecs[v].types;
         req_data  = 32'hA3A2A1A0;
         req_valid = vecs[v].valid;
         if (vecs[v].exp_entry) begin
            et = vecs[v].types[2*vecs[v].exp_src +: 2];
            push(vecs[v].exp_src, et, 8'hA0 + 8'(vecs[v].exp_src));
         end
         tick(1'b0);
         chk("vec_ready", 32'(rdy), 32'(vecs[v].exp_ready));
         req_valid = '0;
         chk("vec_drop", 32'(drop_count), 32'((vecs[v].exp_ready != 0) && !vecs[v].exp_entry));
         chk("vec_out_valid", 32'(out_valid), 32'(vecs[v].exp_entry));
         tick(1'b0);
         chk("vec_fwd", 32'(fwd_count), 32'(vecs[v].exp_entry));
         chk("vec_empty", 32'(out_valid), 0);
      end

      // Two clients forwarded back to back.
      do_reset();
      set_level(2'd3);
      set_client(0, 2'd0, 8'h11);
      set_client(2, 2'd0, 8'h22);
      push(2'd0, 2'd0, 8'h11);
      push(2'd2, 2'd0, 8'h22);
      tick(1'b0); chk("b2b_ready0", 32'(rdy), 32'h1);
      tick(1'b0); chk("b2b_ready1", 32'(rdy), 32'h4);
      chk("b2b_valid", 32'(out_valid), 1);
      tick(1'b0);
      chk("b2b_fwd", 32'(fwd_count), 2);
      chk("b2b_empty", 32'(out_valid), 0);

      // All clients held valid: strict rotation.
      do_reset();
      set_level(2'd3);
      req_data = 32'hA3A2A1A0; req_type = '0; req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) push(2'(k % 4), 2'd0, 8'hA0 + 8'(k % 4));
      for (int k = 0; k < 6; k++) begin
         tick(1'b1);
         chk("rr_ready", 32'(rdy), 32'(1 << (k % 4)));
      end
      req_valid = '0;
      tick(1'b0);
      chk("rr_fwd", 32'(fwd_count), 6);

      // ERROR level: INFO request dropped, ERROR request forwarded.
      do_reset();
      set_level(2'd1);
      set_client(1, 2'd0, 8'hD4);
      tick(1'b0);
      chk("err_drop_ready", 32'(rdy), 32'h2);
      chk("err_drop_count", 32'(drop_count), 1);
      chk("err_drop_noentry", 32'(out_valid), 0);
      set_client(3, 2'd2, 8'hE5);
      push(2'd3, 2'd2, 8'hE5);
      tick(1'b0);
      chk("err_fwd_ready", 32'(rdy), 32'h8);
      chk("err_fwd_entry", 32'({out_valid, out_src, out_type, out_data}), 32'({1'b1, 2'd3, 2'd2, 8'hE5}));
      tick(1'b0);
      chk("err_fwd_count", 32'(fwd_count), 1);

      // Stalled sink: outputs stable, requester blocked, then drain + accept.
      do_reset();
      set_level(2'd1);
      out_ready = 1'b0;
      set_client(0, 2'd2, 8'h5A);
      push(2'd0, 2'd2, 8'h5A);
      tick(1'b0);
      chk("stall_first_ready", 32'(rdy), 32'h1);
      set_client(2, 2'd2, 8'h77);
      for (int k = 0; k < 5; k++) begin
         tick(1'b0);
         chk("stall_ready", 32'(rdy), 0);
         chk("stall_entry", 32'({out_valid, out_src, out_type, out_data}), 32'({1'b1, 2'd0, 2'd2, 8'h5A}));
      end
      out_ready = 1'b1;
      push(2'd2, 2'd2, 8'h77);
      tick(1'b0);
      chk("stall_release_ready", 32'(rdy), 32'h4);
      chk("stall_refill", 32'({out_valid, out_src, out_data}), 32'({1'b1, 2'd2, 8'h77}));
      tick(1'b0);
      chk("stall_fwd", 32'(fwd_count), 2);
      chk("stall_empty", 32'(out_valid), 0);

      // OFF level: every request dropped, nothing forwarded.
      do_reset();
      req_type = 8'hAA; req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick(1'b0);
         chk("off_ready", 32'(rdy), 32'(1 << k));
         chk("off_no_entry", 32'(out_valid), 0);
      end
      chk("off_drop", 32'(drop_count), 4);

      // Asynchronous reset with an entry held and counts nonzero.
      do_reset();
      set_level(2'd1);
      set_client(1, 2'd2, 8'h31);
      push(2'd1, 2'd2, 8'h31);
      tick(1'b0);
      tick(1'b0);
      set_client(0, 2'd0, 8'h30);
      tick(1'b0);
      out_ready = 1'b0;
      set_client(2, 2'd2, 8'h42);
      tick(1'b0);
      chk("arst_pre", 32'({out_valid, fwd_count, drop_count}), 32'({1'b1, 16'd1, 16'd1}));
      rst_n = 1'b0;
      #1;
      chk("arst_clear", 32'({out_valid, fwd_count, drop_count}), 0);
      rst_n = 1'b1;
      sb_q.delete();
      req_valid = '0;
      set_level(2'd3);
      out_ready = 1'b1;
      set_client(0, 2'd0, 8'h50);
      set_client(1, 2'd0, 8'h51);
      push(2'd0, 2'd0, 8'h50);
      push(2'd1, 2'd0, 8'h51);
      tick(1'b0);
      chk("arst_first_grant", 32'(rdy), 32'h1);
`ifdef LOG_ARB_TIMESTAMP_EN
      chk("arst_ts", 32'(out_ts), 1);
`endif
      tick(1'b0);
      chk("arst_second_grant", 32'(rdy), 32'h2);
      tick(1'b0);
      chk("arst_fwd", 32'(fwd_count), 2);

      // Drop counter saturation.
      do_reset();
      set_client(0, 2'd2, 8'h00);
      for (int k = 0; k < 65534; k++) tick(1'b1);
      chk("sat_below", 32'(drop_count), 32'hFFFE);
      for (int k = 0; k < 6; k++) tick(1'b1);
      chk("sat_hold", 32'(drop_count), 32'hFFFF);
      req_valid = '0;

      chk("sb_drained", 32'(sb_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
